mips_multicycle_control: RTL and testbench

MIPS_MULTICYCLE_CONTROL -- requirements
Module: mips_multicycle_control

---
 rtl/mips_multicycle_control.sv | 190 +++++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control unit: a Moore FSM that sequences fetch, decode,
// memory, ALU, branch and jump steps. It waits on the memReady handshake only
// during instruction fetch and data memory access.
// Optional feature macro: BNE_EN adds a BNE state for opcode 000101.
// Without BNE_EN, opcode 000101 is treated as an illegal opcode.
module mips_multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       memReady,
  output logic       IorD,
  output logic       memWrite,
  output logic       irWrite,
  output logic       regDst,
  output logic       memToReg,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic       branch,
  output logic       branchNe,
  output logic       pcWrite,
  output logic       illegalOp,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic [1:0] pcSrc,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQ     = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_BNE     = 4'd12
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef BNE_EN
  localparam logic [5:0] OP_BNE  = 6'b000101;
`endif

  state_t state_reg;
  state_t state_next;
  // Remembers whether the decoded instruction was sw.
  // The opcode input is only guaranteed valid while the FSM is in DECODE.
  logic   is_sw_reg;

  assign state = state_reg;

  // State register: asynchronous reset aborts any instruction back to FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Capture the load/store direction during DECODE for use in MEMADR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_sw_reg <= 1'b0;
    end else if (state_reg == S_DECODE) begin
      is_sw_reg <= (opcode == OP_SW);
    end
  end

  // Next-state and output decode. Every output defaults to 0.
  // Reset then overrides the write strobes.
  always_comb begin
    state_next = S_FETCH;
    IorD       = 1'b0;
    memWrite   = 1'b0;
    irWrite    = 1'b0;
    regDst     = 1'b0;
    memToReg   = 1'b0;
    regWrite   = 1'b0;
    aluSrcA    = 1'b0;
    branch     = 1'b0;
    branchNe   = 1'b0;
    pcWrite    = 1'b0;
    illegalOp  = 1'b0;
    aluSrcB    = 2'b00;
    aluOp      = 2'b00;
    pcSrc      = 2'b00;

    case (state_reg)
      S_FETCH: begin
        aluSrcB    = 2'b01;
        irWrite    = memReady;
        pcWrite    = memReady;
        state_next = memReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        aluSrcB = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYP:      state_next = S_EXECUTE;
          OP_BEQ:       state_next = S_BEQ;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
`ifdef BNE_EN
          OP_BNE:       state_next = S_BNE;
`endif
          default: begin
            state_next = S_FETCH;
            illegalOp  = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        aluSrcA    = 1'b1;
        aluSrcB    = 2'b10;
        state_next = is_sw_reg ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        IorD       = 1'b1;
        state_next = memReady ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memToReg = 1'b1;
        regWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD       = 1'b1;
        memWrite   = 1'b1;
        state_next = memReady ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        aluSrcA    = 1'b1;
        aluOp      = 2'b10;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        regDst   = 1'b1;
        regWrite = 1'b1;
      end
      S_BEQ: begin
        aluSrcA = 1'b1;
        aluOp   = 2'b01;
        pcSrc   = 2'b01;
        branch  = 1'b1;
      end
      S_ADDIEX: begin
        aluSrcA    = 1'b1;
        aluSrcB    = 2'b10;
        state_next = S_ADDIWB;
      end
      S_ADDIWB: begin
        regWrite = 1'b1;
      end
      S_JUMP: begin
        pcSrc   = 2'b10;
        pcWrite = 1'b1;
      end
`ifdef BNE_EN
      S_BNE: begin
        aluSrcA  = 1'b1;
        aluOp    = 2'b11;
        pcSrc    = 2'b01;
        branchNe = 1'b1;
      end
`endif
      default: state_next = S_FETCH;
    endcase

    // Reset gating: the state is already FETCH, so this only has to
    // suppress the handshake-driven fetch strobes.
    if (rst) begin
      pcWrite   = 1'b0;
      irWrite   = 1'b0;
      regWrite  = 1'b0;
      memWrite  = 1'b0;
      illegalOp = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control. Directed instruction sequences are
// expanded into per-cycle phase lists, and the expected outputs for each
// phase come from a small table model. One negedge process compares the DUT
// against the model every cycle. Literal checks pin strobe counts and
// instruction latencies.
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       memReady = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       IorD, memWrite, irWrite, regDst, memToReg, regWrite, aluSrcA;
  logic       branch, branchNe, pcWrite, illegalOp;
  logic [1:0] aluSrcB, aluOp, pcSrc;
  logic [3:0] state;

  mips_multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .memReady(memReady),
    .IorD(IorD), .memWrite(memWrite), .irWrite(irWrite), .regDst(regDst),
    .memToReg(memToReg), .regWrite(regWrite), .aluSrcA(aluSrcA),
    .branch(branch), .branchNe(branchNe), .pcWrite(pcWrite),
    .illegalOp(illegalOp), .aluSrcB(aluSrcB), .aluOp(aluOp), .pcSrc(pcSrc),
    .state(state)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [20:0] exp_vec = '0;
  logic        exp_valid = 1'b0;
  string       exp_tag = "";
  logic [20:0] dut_vec;
  logic        tog = 1'b0;
  int          cnt_mw, cnt_ill, cnt_rw, cnt_iord, cnt_m2r;

  assign dut_vec = {state, IorD, memWrite, irWrite, regDst, memToReg, regWrite,
                    aluSrcA, branch, branchNe, pcWrite, illegalOp,
                    aluSrcB, aluOp, pcSrc};

  // Expected outputs for a phase, taken from the control table.
  // Phase numbers are the documented state codes.
  function automatic logic [20:0] model_vec(input int ph, input logic r,
                                            input logic mr, input logic ill);
    logic iord, mw, irw, rd, m2r, rw, asa, br, bn, pw, il;
    logic [1:0] asb, aop, psrc;
    logic [3:0] code;
    {iord, mw, irw, rd, m2r, rw, asa, br, bn, pw, il} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    code = ph[3:0];
    case (ph)
      0:  begin asb = 2'b01; irw = mr & ~r; pw = mr & ~r; end
      1:  begin asb = 2'b11; il = ill; end
      2:  begin asa = 1'b1; asb = 2'b10; end
      3:  iord = 1'b1;
      4:  begin m2r = 1'b1; rw = 1'b1; end
      5:  begin iord = 1'b1; mw = 1'b1; end
      6:  begin asa = 1'b1; aop = 2'b10; end
      7:  begin rd = 1'b1; rw = 1'b1; end
      8:  begin asa = 1'b1; aop = 2'b01; psrc = 2'b01; br = 1'b1; end
      9:  begin asa = 1'b1; asb = 2'b10; end
      10: rw = 1'b1;
      11: begin psrc = 2'b10; pw = 1'b1; end
      12: begin asa = 1'b1; aop = 2'b11; psrc = 2'b01; bn = 1'b1; end
      default: ;
    endcase
    return {code, iord, mw, irw, rd, m2r, rw, asa, br, bn, pw, il, asb, aop, psrc};
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (exp_valid) begin
      total++;
      if (dut_vec !== exp_vec) begin
        bad++;
        $display("FAIL cycle %s: got %h want %h", exp_tag, dut_vec, exp_vec);
      end
    end
  end

  task automatic lit(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  // Drives one cycle of inputs, publishes the expected phase, and counts strobes.
  task automatic step(input logic r, input logic mr, input logic [5:0] op,
                      input int ph, input logic ill, input string tag);
    @(posedge clk);
    #1;
    rst = r; memReady = mr; opcode = op;
    exp_vec = model_vec(ph, r, mr, ill);
    exp_tag = tag;
    exp_valid = 1'b1;
    @(negedge clk);
    if (memWrite)  cnt_mw++;
    if (illegalOp) cnt_ill++;
    if (regWrite)  cnt_rw++;
    if (IorD)      cnt_iord++;
    if (memToReg)  cnt_m2r++;
    $display("cyc %s rst=%0b mr=%0b op=%b state=%0d", tag, r, mr, op, state);
  endtask

  // Expands one instruction into its phase sequence and runs it.
  // fw and mw are wait cycles for fetch and data memory. lat returns cycles spent.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                           input string nm, output int lat);
    int   ph_q[$];
    logic mr_q[$];
    logic ill;
    int   n;
    n = 0;
    cnt_mw = 0; cnt_ill = 0; cnt_rw = 0; cnt_iord = 0; cnt_m2r = 0;
    ill = 1'b0;
    case (op)
      6'b100011: begin
        ph_q.push_back(2); mr_q.push_back(tog);
        for (int i = 0; i < mw; i++) begin ph_q.push_back(3); mr_q.push_back(1'b0); end
        ph_q.push_back(3); mr_q.push_back(1'b1);
        ph_q.push_back(4); mr_q.push_back(~tog);
      end
      6'b101011: begin
        ph_q.push_back(2); mr_q.push_back(tog);
        for (int i = 0; i < mw; i++) begin ph_q.push_back(5); mr_q.push_back(1'b0); end
        ph_q.push_back(5); mr_q.push_back(1'b1);
      end
      6'b000000: begin
        ph_q.push_back(6); mr_q.push_back(tog);
        ph_q.push_back(7); mr_q.push_back(~tog);
      end
      6'b000100: begin ph_q.push_back(8); mr_q.push_back(~tog); end
      6'b001000: begin
        ph_q.push_back(9); mr_q.push_back(~tog);
        ph_q.push_back(10); mr_q.push_back(tog);
      end
      6'b000010: begin ph_q.push_back(11); mr_q.push_back(tog); end
`ifdef BNE_EN
      6'b000101: begin ph_q.push_back(12); mr_q.push_back(~tog); end
`endif
      default: ill = 1'b1;
    endcase
    for (int i = 0; i < fw; i++) begin
      step(1'b0, 1'b0, op, 0, 1'b0, {nm, "_fetchwait"}); n++;
    end
    step(1'b0, 1'b1, op, 0, 1'b0, {nm, "_fetch"}); n++;
    step(1'b0, tog, op, 1, ill, {nm, "_decode"}); n++;
    tog = ~tog;
    foreach (ph_q[i]) begin
      // Opcode is deliberately scrambled after DECODE.
      step(1'b0, mr_q[i], 6'h3f, ph_q[i], 1'b0, $sformatf("%s_ph%0d", nm, ph_q[i]));
      n++;
    end
    lat = n;
  endtask

  initial begin
    int lat;
    // Hold reset while toggling memReady.
    for (int i = 0; i < 4; i++) step(1'b1, i[0], 6'b100011, 0, 1'b0, "reset");
    lit("reset_state", int'(state), 0);
    lit("reset_alusrcb", int'(aluSrcB), 1);
    lit("reset_strobes", cnt_mw + cnt_rw, 0);

    run_instr(6'b100011, 0, 0, "lw", lat);
    lit("lw_latency", lat, 5);
    lit("lw_regwrite_cycles", cnt_rw, 1);
    lit("lw_memtoreg_cycles", cnt_m2r, 1);

    run_instr(6'b101011, 0, 0, "sw", lat);
    lit("sw_latency", lat, 4);

    run_instr(6'b101011, 2, 3, "sw_wait", lat);
    lit("sw_wait_memwrite_cycles", cnt_mw, 4);
    lit("sw_wait_iord_cycles", cnt_iord, 4);

    run_instr(6'b000000, 0, 0, "rtype", lat);
    lit("rtype_latency", lat, 4);
    run_instr(6'b001000, 1, 0, "addi", lat);
    lit("addi_latency", lat, 5);
    run_instr(6'b000100, 0, 0, "beq", lat);
    lit("beq_latency", lat, 3);
    run_instr(6'b000010, 0, 0, "j", lat);
    lit("j_latency", lat, 3);
    run_instr(6'b100011, 1, 2, "lw_wait", lat);
    lit("lw_wait_latency", lat, 8);

    run_instr(6'b000101, 0, 0, "bne", lat);
`ifdef BNE_EN
    lit("bne_latency", lat, 3);
    lit("bne_illegal_cycles", cnt_ill, 0);
`else
    lit("bne_latency", lat, 2);
    lit("bne_illegal_cycles", cnt_ill, 1);
`endif

    run_instr(6'b111111, 0, 0, "illegal", lat);
    lit("illegal_cycles", cnt_ill, 1);
    lit("illegal_latency", lat, 2);

    // Reset asserted while a store is waiting in MEMWR.
    step(1'b0, 1'b1, 6'b101011, 0, 1'b0, "abort_fetch");
    step(1'b0, 1'b0, 6'b101011, 1, 1'b0, "abort_decode");
    step(1'b0, 1'b1, 6'h3f, 2, 1'b0, "abort_memadr");
    step(1'b0, 1'b0, 6'h3f, 5, 1'b0, "abort_memwr");
    lit("abort_memwrite_before", int'(memWrite), 1);
    step(1'b1, 1'b1, 6'h3f, 0, 1'b0, "abort_rst");
    lit("abort_memwrite_during_rst", int'(memWrite), 0);
    lit("abort_state_during_rst", int'(state), 0);
    step(1'b0, 1'b0, 6'h3f, 0, 1'b0, "abort_release");

    run_instr(6'b000000, 0, 0, "rtype_after_rst", lat);
    lit("rtype_after_rst_latency", lat, 4);

    exp_valid = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
